// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } bcd_serial_state_t;

  localparam int unsigned FLAG_ZERO    = 0;
  localparam int unsigned FLAG_CARRY   = 1;
  localparam int unsigned FLAG_INVALID = 2;

  function automatic logic is_invalid_digit(input bcd_digit_t d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single BCD digit add/subtract step with decimal carry/borrow.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  logic       add_sub,
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] r_d,
  output logic       c_out
);

  logic [4:0] w_t;
  logic       w_carry;

  always_comb begin
    if (add_sub) begin
      w_t = {1'b0, a_d} - {1'b0, b_d} - {4'b0000, c_in};
    end else begin
      w_t = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c_in};
    end
    // A negative subtract wraps to >= 22 mod 32, so one threshold serves both ops.
    w_carry = (w_t > 5'd9);
    if (w_carry) begin
      r_d = add_sub ? (w_t[3:0] - 4'd6) : (w_t[3:0] + 4'd6);
    end else begin
      r_d = w_t[3:0];
    end
    c_out = w_carry;
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional: define BCD_INVALID_DETECT_EN to report non-decimal operand digits in flags[2].
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  add_sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  carry_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   r,
  output logic [3:0]            flags
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  bcd_serial_state_t r_state;
  bcd_serial_state_t w_state_next;

  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [4*DIGITS-1:0] r_r;
  logic                r_sub;
  logic                r_carry;
  logic [IW-1:0]       r_idx;
  logic [3:0]          r_flags;

  logic                w_accept;
  logic                w_last;
  logic [3:0]          w_a_d;
  logic [3:0]          w_b_d;
  logic [3:0]          w_r_d;
  logic                w_c_out;
  logic [4*DIGITS-1:0] w_r_next;
  logic                w_invalid;

  assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_idx == LAST_IDX);
  assign r         = r_r;
  assign flags     = r_flags;

  always_comb begin
    w_a_d = r_a[4*r_idx +: 4];
    w_b_d = r_b[4*r_idx +: 4];
  end

  bcd_digit_addsub u_digit (
    .add_sub (r_sub),
    .a_d     (w_a_d),
    .b_d     (w_b_d),
    .c_in    (r_carry),
    .r_d     (w_r_d),
    .c_out   (w_c_out)
  );

  always_comb begin
    w_r_next = r_r;
    w_r_next[4*r_idx +: 4] = w_r_d;
  end

`ifdef BCD_INVALID_DETECT_EN
  always_comb begin
    w_invalid = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (is_invalid_digit(r_a[4*i +: 4]) || is_invalid_digit(r_b[4*i +: 4])) begin
        w_invalid = 1'b1;
      end
    end
  end
`else
  assign w_invalid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        // Back-to-back: a consumed result can be replaced on the same edge.
        if (out_ready) w_state_next = in_valid ? ST_BUSY : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= add_sub;
      r_carry <= carry_in;
      r_r     <= '0;
      r_idx   <= '0;
      r_flags <= '0;
    end else if (r_state == ST_BUSY) begin
      r_r     <= w_r_next;
      r_carry <= w_c_out;
      if (w_last) begin
        r_idx                 <= '0;
        r_flags[FLAG_ZERO]    <= (w_r_next == '0);
        r_flags[FLAG_CARRY]   <= w_c_out;
        r_flags[FLAG_INVALID] <= w_invalid;
        r_flags[3]            <= 1'b0;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial: decimal reference model plus directed literals.
// Expectations for flags[2] follow BCD_INVALID_DETECT_EN as defined for the build.
module tb_bcd_addsub_serial;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         add_sub = 1'b0;
  logic         carry_in = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] r;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_sub   (add_sub),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .flags     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- decimal reference model ----------------
  function automatic int pow10n();
    int m = 1;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    return m;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] x);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] x = '0;
    for (int i = 0; i < DIGITS; i++) begin
      x[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return x;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] x, input logic [W-1:0] y);
    logic bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  task automatic model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic sub,
                       input logic cin, output logic [W-1:0] rr, output logic [3:0] ff);
    int  m = pow10n();
    int  s;
    logic c;
    logic inv;
    if (!sub) begin
      s = bcd2int(aa) + bcd2int(bb) + int'(cin);
      c = (s >= m);
      if (c) s = s - m;
    end else begin
      s = bcd2int(aa) - bcd2int(bb) - int'(cin);
      c = (s < 0);
      if (c) s = s + m;
    end
`ifdef BCD_INVALID_DETECT_EN
    inv = has_bad(aa, bb);
`else
    inv = 1'b0;
`endif
    rr = int2bcd(s);
    ff = {1'b0, inv, c, (s == 0)};
  endtask

  // ---------------- per-cycle compare process ----------------
  logic         armed = 1'b0;
  logic         pend = 1'b0;
  logic         pend_skip = 1'b0;
  logic         ev;
  int           due = 0;
  logic [W-1:0] e_r;
  logic [3:0]   e_f;

  always @(negedge clk) begin
    ev = pend && (cyc >= due);
    if (armed) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!pend || (ev && out_ready))});
      if (ev && out_valid) begin
        if (pend_skip) begin
          chk("flags_invalid", {31'b0, flags[2]}, {31'b0, e_f[2]});
        end else begin
          chk("r", {16'b0, r}, {16'b0, e_r});
          chk("flags", {28'b0, flags}, {28'b0, e_f});
        end
      end
    end
    if (reset) begin
      pend  = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      if (ev && out_ready) pend = 1'b0;
      if (in_valid && !pend) begin
        model(a, b, add_sub, carry_in, e_r, e_f);
        pend_skip = has_bad(a, b);
        pend      = 1'b1;
        due       = cyc + 1 + DIGITS;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic sub, input logic cin);
    int n;
    a = aa; b = bb; add_sub = sub; carry_in = cin; in_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic sub, input logic cin,
                        input logic [W-1:0] exp_r, input logic [3:0] exp_f);
    int lat;
    issue(aa, bb, sub, cin);
    wait_result(lat);
    chk({name, "_latency"}, lat, DIGITS);
    chk({name, "_r"}, {16'b0, r}, {16'b0, exp_r});
    chk({name, "_flags"}, {28'b0, flags}, {28'b0, exp_f});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n;
    for (int i = 0; i < DIGITS; i++) begin
      ra[4*i +: 4] = 4'($urandom_range(0, 9));
      rb[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      #1 out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) break;
    end
    if (n == 100) begin
      checks++; errors++;
      $display("FAIL result_timeout: got no handshake expected result within 100 cycles");
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] mr;
  logic [3:0]   mf;
  int           lat;

  initial begin
    // Pin the reference model to hand-computed values.
    model(16'h1234, 16'h8766, 1'b0, 1'b0, mr, mf);
    chk("pin_add", {12'b0, mr, mf}, {12'b0, 16'h0000, 4'b0011});
    model(16'h0100, 16'h0001, 1'b1, 1'b0, mr, mf);
    chk("pin_sub", {12'b0, mr, mf}, {12'b0, 16'h0099, 4'b0000});
    model(16'h0000, 16'h0001, 1'b1, 1'b0, mr, mf);
    chk("pin_wrap", {12'b0, mr, mf}, {12'b0, 16'h9999, 4'b0010});

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_r", {16'b0, r}, 32'h0);
    chk("rst_flags", {28'b0, flags}, 32'h0);
    @(posedge clk);
    #1;

    run_op("add_1234_8766", 16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 4'b0011);
    run_op("sub_0100_0001", 16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0099, 4'b0000);
    run_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 4'b0010);
    run_op("add_9999_cin", 16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b0011);

    // Backpressure then back-to-back accept on the releasing edge.
    out_ready = 1'b0;
    issue(16'h0012, 16'h0034, 1'b0, 1'b0);
    wait_result(lat);
    chk("bp_latency", lat, DIGITS);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_r", {16'b0, r}, 32'h0046);
      chk("bp_flags", {28'b0, flags}, 32'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    a = 16'h0005; b = 16'h0005; add_sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    chk("b2b_latency", lat, DIGITS);
    chk("b2b_r", {16'b0, r}, 32'h0010);
    @(posedge clk);
    #1;

    // Reset while digit 2 is about to be written.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_r", {16'b0, r}, 32'h0);
    @(posedge clk);
    #1;
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 4'b0000);

`ifdef BCD_INVALID_DETECT_EN
    run_op("invalid", 16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 4'b0100);
`else
    run_op("invalid", 16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 4'b0000);
`endif

    for (int k = 0; k < 150; k++) rand_op();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
